// File: rtl/sdram_test_pkg.sv
// Shared state/pattern types and constants for the SDRAM pattern tester.
// Used by sdram_pattern_gen and sdram_pattern_tester.
package sdram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } tester_state_e;

    typedef enum logic [1:0] {
        PAT_CONST    = 2'd0,
        PAT_ADDR     = 2'd1,
        PAT_INV_ADDR = 2'd2,
        PAT_WALK_ONE = 2'd3
    } pattern_sel_e;

    localparam logic [31:0] PATTERN_CONST = 32'h0000_0100;

    function automatic pattern_sel_e next_pattern(input pattern_sel_e sel);
        return pattern_sel_e'(2'(sel) + 2'd1);
    endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test-pattern generator: (address, pattern select) -> data.
// One instance feeds both the write data and the read-compare reference.
module sdram_pattern_gen
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  pattern_sel_e      sel_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] addr_fit;
    logic [ADDR_W-1:0] bit_idx;
    logic [DATA_W-1:0] walk;

    if (DATA_W > ADDR_W) begin : g_ext
        assign addr_fit = {{(DATA_W-ADDR_W){1'b0}}, addr_i};
    end else begin : g_trunc
        assign addr_fit = addr_i[DATA_W-1:0];
    end

    assign bit_idx = addr_i % ADDR_W'(DATA_W);
    assign walk    = DATA_W'(1) << bit_idx;

    always_comb begin
        unique case (sel_i)
            PAT_ADDR:     data_o = addr_fit;
            PAT_INV_ADDR: data_o = ~addr_fit;
            PAT_WALK_ONE: data_o = walk;
            default:      data_o = PATTERN_CONST[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Write-then-read-back SDRAM pattern tester with first-failure capture.
// Define SDRAM_TESTER_LOOP_EN to repeat passes with a rotating pattern.
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int          ADDR_W     = 25,
    parameter int          DATA_W     = 16,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned END_ADDR   = 100
) (
    input  logic              inputClock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        patternSel,
    input  logic              isBusy,
    input  logic              inputDataAvailable,
    input  logic [DATA_W-1:0] inputData,
    output logic              isWriting,
    output logic              outputValid,
    output logic [ADDR_W-1:0] outputAddress,
    output logic [DATA_W-1:0] outputData,
    output logic              running,
    output logic              compareError,
    output logic              completedSuccess,
    output logic [ADDR_W-1:0] errorAddress,
    output logic [DATA_W-1:0] errorExpected,
    output logic [DATA_W-1:0] errorActual,
    output logic [15:0]       passCount
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(END_ADDR);

    tester_state_e     state_q, state_d;
    pattern_sel_e      sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              got_q, got_d;
    logic              valid_q, valid_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              run_q, run_d;
    logic              err_q, err_d;
    logic              ok_q, ok_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [DATA_W-1:0] eexp_q, eexp_d;
    logic [DATA_W-1:0] eact_q, eact_d;
    logic [15:0]       pass_q, pass_d;

    logic              fail_now;
    logic [DATA_W-1:0] fail_act;
    logic              read_done;
    logic [DATA_W-1:0] pat_data;

    sdram_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_gen (
        .addr_i (addr_d),
        .sel_i  (sel_d),
        .data_o (pat_data)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        got_d     = got_q;
        run_d     = run_q;
        err_d     = err_q;
        ok_d      = ok_q;
        eaddr_d   = eaddr_q;
        eexp_d    = eexp_q;
        eact_d    = eact_q;
        pass_d    = pass_q;
        fail_now  = 1'b0;
        fail_act  = '0;
        read_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !isBusy) begin
                    state_d = ST_WR_REQ;
                    sel_d   = pattern_sel_e'(patternSel);
                    addr_d  = FIRST;
                    run_d   = 1'b1;
                    err_d   = 1'b0;
                    ok_d    = 1'b0;
                    eaddr_d = '0;
                    eexp_d  = '0;
                    eact_d  = '0;
                    pass_d  = '0;
                end
            end
            ST_WR_REQ: begin
                if (isBusy) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (!isBusy) begin
                    if (addr_q == LAST) begin
                        addr_d  = FIRST;
                        state_d = ST_RD_REQ;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (isBusy) begin
                    state_d = ST_RD_WAIT;
                    got_d   = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                // A strobe in the same cycle as busy falling is compared first.
                if (inputDataAvailable) begin
                    got_d = 1'b1;
                    if (inputData != odata_q) begin
                        fail_now = 1'b1;
                        fail_act = inputData;
                    end else if (!isBusy) begin
                        read_done = 1'b1;
                    end
                end else if (!isBusy) begin
                    if (!got_q) fail_now  = 1'b1;
                    else        read_done = 1'b1;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail_now) begin
            state_d = ST_FAIL;
            run_d   = 1'b0;
            err_d   = 1'b1;
            eaddr_d = addr_q;
            eexp_d  = odata_q;
            eact_d  = fail_act;
        end

        if (read_done) begin
            if (addr_q == LAST) begin
                pass_d = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
`ifdef SDRAM_TESTER_LOOP_EN
                if (start) begin
                    state_d = ST_WR_REQ;
                    addr_d  = FIRST;
                    sel_d   = next_pattern(sel_q);
                end else begin
                    state_d = ST_DONE;
                    run_d   = 1'b0;
                    ok_d    = 1'b1;
                end
`else
                state_d = ST_DONE;
                run_d   = 1'b0;
                ok_d    = 1'b1;
`endif
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_RD_REQ;
            end
        end

        // Request outputs are registered from the next state.
        valid_d = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        wr_d    = (state_d == ST_WR_REQ);
        oaddr_d = valid_d ? addr_d : oaddr_q;
        odata_d = valid_d ? pat_data : odata_q;
    end

    always_ff @(posedge inputClock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= PAT_CONST;
            addr_q  <= '0;
            got_q   <= 1'b0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
            eaddr_q <= '0;
            eexp_q  <= '0;
            eact_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            got_q   <= got_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            run_q   <= run_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            eaddr_q <= eaddr_d;
            eexp_q  <= eexp_d;
            eact_q  <= eact_d;
            pass_q  <= pass_d;
        end
    end

    assign isWriting        = wr_q;
    assign outputValid      = valid_q;
    assign outputAddress    = oaddr_q;
    assign outputData       = odata_q;
    assign running          = run_q;
    assign compareError     = err_q;
    assign completedSuccess = ok_q;
    assign errorAddress     = eaddr_q;
    assign errorExpected    = eexp_q;
    assign errorActual      = eact_q;
    assign passCount        = pass_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: SDRAM controller model with fault
// injection, vector table, random runs, reset and loop sequences.
module tb_sdram_pattern_tester;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int SA = 0;
    localparam int EA = 100;

    typedef struct {
        int sel;
        int late;
        int blen;
        int corr;
        int cval;
        int drop;
        int err;
        int eaddr;
        int eexp;
        int eact;
        int done;
        int pass;
        int nwr;
        int nrd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    patternSel;
    logic          isBusy;
    logic          inputDataAvailable;
    logic [DW-1:0] inputData;
    logic          isWriting;
    logic          outputValid;
    logic [AW-1:0] outputAddress;
    logic [DW-1:0] outputData;
    logic          running;
    logic          compareError;
    logic          completedSuccess;
    logic [AW-1:0] errorAddress;
    logic [DW-1:0] errorExpected;
    logic [DW-1:0] errorActual;
    logic [15:0]   passCount;

    logic mbusy;
    logic force_busy;
    int   n_tests = 0;
    int   n_fail = 0;
    int   bcnt, rd_addr, exp_wr, exp_rd, nwr, nrd, cur_sel;
    int   late, blen, corr_addr, corr_val, drop_addr;
    bit   rd_pend;
    logic [DW-1:0] mem [0:255];

    assign isBusy = mbusy | force_busy;

    always #5 clk = ~clk;

    sdram_pattern_tester #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .START_ADDR (SA),
        .END_ADDR   (EA)
    ) dut (
        .inputClock         (clk),
        .reset_n            (rst_n),
        .start              (start),
        .patternSel         (patternSel),
        .isBusy             (isBusy),
        .inputDataAvailable (inputDataAvailable),
        .inputData          (inputData),
        .isWriting          (isWriting),
        .outputValid        (outputValid),
        .outputAddress      (outputAddress),
        .outputData         (outputData),
        .running            (running),
        .compareError       (compareError),
        .completedSuccess   (completedSuccess),
        .errorAddress       (errorAddress),
        .errorExpected      (errorExpected),
        .errorActual        (errorActual),
        .passCount          (passCount)
    );

    function automatic logic [15:0] exp_pat(input int sel, input int a);
        case (sel)
            0:       return 16'h0100;
            1:       return a[15:0];
            2:       return ~a[15:0];
            default: return 16'd1 << (a % 16);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_running(input logic lvl, input int budget,
                                input string nm);
        int n;
        n = 0;
        while (running !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(running), 64'(lvl));
    endtask

    task automatic cfg(input vec_t v);
        late      = v.late;
        blen      = v.blen;
        corr_addr = v.corr;
        corr_val  = v.cval;
        drop_addr = v.drop;
        cur_sel   = v.sel;
        nwr       = 0;
        nrd       = 0;
        exp_wr    = SA;
        exp_rd    = SA;
    endtask

    task automatic do_run(input vec_t v);
        cfg(v);
        @(negedge clk);
        patternSel = 2'(v.sel);
        start = 1'b1;
        wait_running(1'b1, 20, "run_start");
        // Changes on start/patternSel while running must be ignored.
        patternSel = 2'($urandom);
        start = 1'b0;
        wait_running(1'b0, 30000, "run_end");
        @(negedge clk);
    endtask

    task automatic check_vec(input string nm, input vec_t v);
        chk({nm, "_cmp_err"}, 64'(compareError), 64'(v.err));
        chk({nm, "_success"}, 64'(completedSuccess), 64'(v.done));
        chk({nm, "_pass_cnt"}, 64'(passCount), 64'(v.pass));
        chk({nm, "_err_addr"}, 64'(errorAddress), 64'(v.eaddr));
        chk({nm, "_err_exp"}, 64'(errorExpected), 64'(v.eexp));
        chk({nm, "_err_act"}, 64'(errorActual), 64'(v.eact));
        chk({nm, "_writes"}, 64'(nwr), 64'(v.nwr));
        chk({nm, "_reads"}, 64'(nrd), 64'(v.nrd));
        chk({nm, "_idle_valid"}, 64'(outputValid), 64'd0);
    endtask

    // SDRAM controller model: busy for blen cycles per request, read data
    // strobed on the last busy cycle (or with busy falling when late != 0).
    initial begin
        mbusy = 1'b0;
        inputDataAvailable = 1'b0;
        inputData = '0;
        bcnt = 0;
        rd_pend = 1'b0;
        rd_addr = 0;
        late = 0;
        blen = 2;
        corr_addr = -1;
        corr_val = 0;
        drop_addr = -1;
        forever begin
            @(negedge clk);
            inputDataAvailable = 1'b0;
            if (!rst_n) begin
                mbusy = 1'b0;
                bcnt = 0;
                rd_pend = 1'b0;
            end else if (bcnt != 0) begin
                bcnt--;
                if (rd_pend && ((bcnt == 1 && late == 0) ||
                                (bcnt == 0 && late != 0))) begin
                    rd_pend = 1'b0;
                    if (rd_addr != drop_addr) begin
                        inputDataAvailable = 1'b1;
                        inputData = (rd_addr == corr_addr) ?
                                    DW'(corr_val) : mem[rd_addr[7:0]];
                    end
                end
                if (bcnt == 0) mbusy = 1'b0;
            end else if (outputValid === 1'b1) begin
                mbusy = 1'b1;
                bcnt = blen;
                if (isWriting) begin
                    if (nwr > 0 && outputAddress == AW'(SA))
                        cur_sel = (cur_sel + 1) % 4;
                    nwr++;
                    chk("wr_addr", 64'(outputAddress), 64'(exp_wr));
                    chk("wr_data", 64'(outputData),
                        64'(exp_pat(cur_sel, exp_wr)));
                    mem[outputAddress[7:0]] = outputData;
                    exp_wr = (exp_wr == EA) ? SA : exp_wr + 1;
                end else begin
                    nrd++;
                    chk("rd_addr", 64'(outputAddress), 64'(exp_rd));
                    rd_pend = 1'b1;
                    rd_addr = int'(outputAddress);
                    exp_rd = (exp_rd == EA) ? SA : exp_rd + 1;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        vec_t v;
        int   n;
        int   kind;
        int   fa;
        int   pc;

        rst_n = 1'b0;
        start = 1'b0;
        patternSel = 2'd0;
        force_busy = 1'b0;

        // sel late blen corr cval drop | err eaddr eexp eact done pass nwr nrd
        tbl[0] = '{0, 0, 2, -1, 0, -1,  0,   0,      0, 0, 1, 1, 101, 101};
        tbl[1] = '{1, 0, 2, 37, 0, -1,  1,  37,  'h025, 0, 0, 0, 101,  38};
        tbl[2] = '{1, 0, 2, -1, 0,  5,  1,   5,  'h005, 0, 0, 0, 101,   6};
        tbl[3] = '{2, 1, 2, -1, 0, -1,  0,   0,      0, 0, 1, 1, 101, 101};
        tbl[4] = '{3, 0, 3, -1, 0, -1,  0,   0,      0, 0, 1, 1, 101, 101};
        tbl[5] = '{3, 0, 2, 17, 0, -1,  1,  17,  'h002, 0, 0, 0, 101,  18};
        tbl[6] = '{2, 0, 2,  0, 0, -1,  1,   0, 'hFFFF, 0, 0, 0, 101,   1};
        tbl[7] = '{0, 1, 2, -1, 0, 100, 1, 100,  'h100, 0, 0, 0, 101, 101};
        tbl[8] = '{2, 1, 4, 100, 0, -1, 1, 100, 'hFF9B, 0, 0, 0, 101, 101};

        repeat (2) @(negedge clk);
        chk("reset_outputs_zero",
            64'(|{isWriting, outputValid, outputAddress, outputData,
                  running, compareError, completedSuccess, errorAddress,
                  errorExpected, errorActual, passCount}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_run(tbl[i]);
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // start is not taken while the controller reports busy
        v = tbl[4];
        cfg(v);
        @(negedge clk);
        force_busy = 1'b1;
        patternSel = 2'd3;
        start = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy_blocks_start", 64'(running), 64'd0);
        chk("busy_blocks_valid", 64'(outputValid), 64'd0);
        force_busy = 1'b0;
        wait_running(1'b1, 20, "busy_release_start");
        start = 1'b0;
        wait_running(1'b0, 30000, "busy_release_end");
        @(negedge clk);
        check_vec("busy_hold", v);

        // reset in the middle of the write request to address 50
        v = tbl[0];
        v.sel = 1;
        cfg(v);
        @(negedge clk);
        patternSel = 2'd1;
        start = 1'b1;
        wait_running(1'b1, 20, "rst_run_start");
        start = 1'b0;
        n = 0;
        while (!(outputValid === 1'b1 && isWriting === 1'b1 &&
                 outputAddress == AW'(50)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_at_addr50", 64'(outputAddress), 64'd50);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_drop", 64'(outputValid), 64'd0);
        chk("rst_all_zero",
            64'(|{isWriting, outputValid, outputAddress, outputData,
                  running, compareError, completedSuccess, errorAddress,
                  errorExpected, errorActual, passCount}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (outputValid !== 1'b0 || running !== 1'b0) n++;
        end
        chk("rst_no_reissue", 64'(n), 64'd0);

        // randomized runs against the reference pattern rules
        for (int r = 0; r < 6; r++) begin
            v = tbl[0];
            v.sel  = int'($urandom_range(0, 3));
            v.late = int'($urandom_range(0, 1));
            v.blen = int'($urandom_range(2, 4));
            kind   = int'($urandom_range(0, 2));
            fa     = int'($urandom_range(SA, EA));
            if (kind == 1) begin
                v.corr  = fa;
                v.cval  = int'(exp_pat(v.sel, fa) ^
                               16'($urandom_range(1, 65535)));
                v.eact  = v.cval;
            end else if (kind == 2) begin
                v.drop  = fa;
                v.eact  = 0;
            end
            if (kind != 0) begin
                v.err   = 1;
                v.eaddr = fa;
                v.eexp  = int'(exp_pat(v.sel, fa));
                v.done  = 0;
                v.pass  = 0;
                v.nrd   = fa - SA + 1;
            end
            do_run(v);
            check_vec($sformatf("rand%0d", r), v);
        end

`ifdef SDRAM_TESTER_LOOP_EN
        // start held across passes: pattern rotates each pass
        v = tbl[0];
        cfg(v);
        @(negedge clk);
        patternSel = 2'd0;
        start = 1'b1;
        wait_running(1'b1, 20, "loop_start");
        n = 0;
        while (passCount < 16'd3 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("loop_reach3", 64'(passCount >= 16'd3), 64'd1);
        start = 1'b0;
        wait_running(1'b0, 5000, "loop_end");
        @(negedge clk);
        pc = int'(passCount);
        chk("loop_pass_ge3", 64'(pc >= 3), 64'd1);
        chk("loop_success", 64'(completedSuccess), 64'd1);
        chk("loop_cmp_err", 64'(compareError), 64'd0);
        chk("loop_writes", 64'(nwr), 64'(pc * 101));
        chk("loop_reads", 64'(nrd), 64'(pc * 101));
        chk("loop_last_sel", 64'(cur_sel), 64'((pc - 1) % 4));
`else
        pc = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
